// File: rtl/instr_feeder.sv
// Instruction-issue stage: buffers host instruction words in a FIFO and presents
// each one on `inn` for HOLD_CYCLES clocks, driving NOP_WORD when nothing is pending.
module instr_feeder #(
    parameter int          DEPTH       = 8,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] NOP_WORD    = 16'h0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [15:0]              wr_data,
    output logic                     wr_ready,
    input  logic                     stall,
    output logic [15:0]              inn,
    output logic                     inn_valid,
    output logic [3:0]               phase,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              issued_count,
    output logic                     state_dbg
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [3:0]    LAST_PHASE = 4'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] inn_d;
    logic        inn_valid_d;
    logic [3:0]  phase_d;

    logic        push;
    logic        pop;
    logic        empty;
    logic        full;
    logic [15:0] head;

    // Handshake: a word transfers on a rising edge where wr_valid && wr_ready;
    // wr_ready depends only on the registered level, never on wr_valid or a same-cycle pop.
    assign full     = (level == FULL_LEVEL);
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;

    // Pointers carry a wrap bit so equal pointers always mean empty, never full.
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            inn          <= NOP_WORD;
            inn_valid    <= 1'b0;
            phase        <= 4'd0;
            issued_count <= 16'd0;
        end else begin
            state_q   <= state_d;
            inn       <= inn_d;
            inn_valid <= inn_valid_d;
            phase     <= phase_d;
            if (pop) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end

    // IDLE pops regardless of stall; ISSUE only advances or pops when not stalled,
    // so `inn` can change only at a pop or on the return to IDLE.
    always_comb begin
        state_d     = state_q;
        inn_d       = inn;
        inn_valid_d = inn_valid;
        phase_d     = phase;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                inn_d       = NOP_WORD;
                inn_valid_d = 1'b0;
                phase_d     = 4'd0;
                if (!empty) begin
                    pop         = 1'b1;
                    inn_d       = head;
                    inn_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (phase != LAST_PHASE) begin
                        phase_d = phase + 4'd1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        inn_d   = head;
                        phase_d = 4'd0;
                    end else begin
                        inn_d       = NOP_WORD;
                        inn_valid_d = 1'b0;
                        phase_d     = 4'd0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_level = level;
    assign state_dbg  = (state_q == ISSUE);

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Instruction-issue stage sitting directly upstream of the 16-bit processor core; its `inn` output drives the core's `inn` instruction input.
- A host or testbench pushes 16-bit instruction words into an internal FIFO over a valid/ready interface.
- The feeder pops one word at a time and holds it stable on `inn` for HOLD_CYCLES clocks, giving the core's multi-step control unit a full execution window.
- When no instruction is pending, `inn` carries NOP_WORD.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- HOLD_CYCLES, 4, clocks each instruction is held on `inn`; range 1..16.
- NOP_WORD, 16'h0000, value driven on `inn` when idle and after reset.

Ports:
- clock  input  1  rising-edge clock shared with the processor.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  host offers `wr_data` this cycle.
- wr_data  input  16  instruction word to enqueue.
- wr_ready  output  1  FIFO can accept a word; a push occurs when wr_valid && wr_ready.
- stall  input  1  freezes the hold-phase counter while high.
- inn  output  16  registered instruction to the processor.
- inn_valid  output  1  1 while `inn` carries a popped instruction; 0 while it carries NOP_WORD.
- phase  output  4  current hold cycle, 0..HOLD_CYCLES-1; 0 when idle.
- fifo_level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- issued_count  output  16  instructions popped since reset; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (asynchronous, any state): FIFO pointers and level cleared; inn=NOP_WORD, inn_valid=0, phase=0, issued_count=0, state=IDLE. wr_ready=1 once reset deasserts. Any in-flight instruction is discarded.
- FIFO:
  - Read/write pointers carry one extra wrap bit.
  - full = (level==DEPTH); wr_ready = !full, combinational from registered level only. A simultaneous pop does not raise wr_ready in the same cycle.
  - A push into a full FIFO is impossible by construction.
  - Simultaneous push and pop leave the level unchanged.
- FSM, two states: IDLE and ISSUE.
  - IDLE: inn=NOP_WORD, inn_valid=0, phase=0. If level>0 at a rising edge, pop the head word: inn<=head, inn_valid<=1, phase<=0, issued_count++, go to ISSUE.
  - A word pushed at edge N is popped at edge N+1 and is visible on `inn` after edge N+1 (2-edge latency from accept to issue).
  - ISSUE, stall=0, phase<HOLD_CYCLES-1: phase++.
  - ISSUE, stall=0, phase==HOLD_CYCLES-1:
    - If level>0, pop the next word back-to-back (inn updates, phase<=0, issued_count++, stay in ISSUE).
    - Otherwise inn<=NOP_WORD, inn_valid<=0, phase<=0, go to IDLE.
  - ISSUE, stall=1: phase, inn and inn_valid are held; no pop. Pushes are still accepted.
  - IDLE ignores stall; a word is popped regardless.
- HOLD_CYCLES=1: every non-empty cycle pops; phase is constantly 0.
- Stability: `inn` changes only at a pop or at the ISSUE->IDLE transition; never mid-hold.
- Pointer wrap: after DEPTH pushes and pops the pointers wrap; order is preserved and full/empty decode stays correct via the wrap bit.
- All outputs are registered except wr_ready, which is decoded from the registered level.

Test Plan:
- Reset mid-hold: push 16'h1234, assert reset at phase=2 -> immediately inn=16'h0000, inn_valid=0, fifo_level=0, issued_count=0; after release, wr_ready=1.
- Single issue: push 16'hA005 at edge 0 -> inn=16'hA005, inn_valid=1 after edge 1; phase runs 0,1,2,3; after edge 5, inn=16'h0000, inn_valid=0, issued_count=1.
- Back-to-back: push 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> each held exactly 4 cycles with no NOP gap; issued_count=3; 12 consecutive cycles with inn_valid=1.
- Full/backpressure: stall=1 after the first pop, push until wr_ready=0 -> fifo_level=8 and wr_ready=0 after 8 further accepted words; a 9th offered word is not accepted; on releasing stall, all 9 words issue in order.
- Stall: during the hold of 16'h00FF, raise stall for 5 cycles at phase=1 -> phase stays 1 and inn stays 16'h00FF; total hold is 9 cycles.
- Wrap: push and issue 20 words 16'h0100..16'h0113 with DEPTH=8 -> issue order is exact, issued_count=20; separately, starting from issued_count forced near wrap, 16'hFFFF+1 -> 0.
